// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
//   Debounces a raw mechanical key. The key is first synchronised into the
//   clk domain. A press or release is accepted only after the new level has
//   been stable for a full window of CNT_MAX clk cycles. Any opposite-level
//   sample inside the window rejects the change and restarts qualification.
//
// Parameters
//   CNT_MAX     debounce window in clk cycles (>= 2)
//   ACTIVE_LOW  1 when the raw key reads 0 while pressed
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   key_in       raw key, asynchronous to clk, may bounce
//   key_out      registered debounced level, 1 = pressed
//   key_press    registered one-cycle pulse on an accepted press
//   key_release  registered one-cycle pulse on an accepted release
// ----------------------------------------------------------------------------
module key_debounce #(
    parameter int unsigned CNT_MAX    = 1000000,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_out,
    output logic key_press,
    output logic key_release
);

    localparam int unsigned   CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
    localparam logic          IDLE_LVL = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        PRESSED    = 2'd2,
        REL_FILT   = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_sync0;
    logic          r_sync1;
    logic          r_key_out;
    logic          r_key_press;
    logic          r_key_release;
    logic          w_key_s;

    // Normalised key level: 1 always means pressed regardless of polarity.
    assign w_key_s = r_sync1 ^ IDLE_LVL;

    // Two-flop synchroniser. Reset loads the idle level so that leaving
    // reset can never look like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0 <= IDLE_LVL;
            r_sync1 <= IDLE_LVL;
        end else begin
            r_sync0 <= key_in;
            r_sync1 <= r_sync0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_key_out     <= 1'b0;
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
        end else begin
            // Pulses are asserted only on the qualifying edge below.
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_key_s) begin
                        r_state <= PRESS_FILT;
                    end
                end
                PRESS_FILT: begin
                    if (!w_key_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state     <= PRESSED;
                        r_cnt       <= '0;
                        r_key_out   <= 1'b1;
                        r_key_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    r_cnt <= '0;
                    if (!w_key_s) begin
                        r_state <= REL_FILT;
                    end
                end
                REL_FILT: begin
                    if (w_key_s) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state       <= IDLE;
                        r_cnt         <= '0;
                        r_key_out     <= 1'b0;
                        r_key_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= '0;
                    r_key_out <= 1'b0;
                end
            endcase
        end
    end

    assign key_out     = r_key_out;
    assign key_press   = r_key_press;
    assign key_release = r_key_release;

endmodule

// File: tb/tb_key_debounce.sv
// ----------------------------------------------------------------------------
// tb_key_debounce
//   Drives an active-high and an active-low instance (CNT_MAX=4) with the same
//   key activity and checks both against a run-length reference model: the
//   debounced level flips once the synchronised key has disagreed with it on
//   CNT_MAX+1 consecutive clock edges.
// ----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int unsigned CNT = 4;

    typedef struct packed {
        logic lvl;
        logic press;
        logic rel;
    } exp_t;

    logic clk = 1'b1;
    logic rst;
    logic kp;                 // key activity, 1 = pressed
    logic key_in_hi;
    logic key_in_lo;
    logic out_hi, press_hi, rel_hi;
    logic out_lo, press_lo, rel_lo;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t q[$];

    // reference model state
    logic m_p0, m_p1, m_lvl;
    int   m_run;

    assign key_in_hi = kp;
    assign key_in_lo = ~kp;

    always #5 clk = ~clk;

    key_debounce #(.CNT_MAX(CNT), .ACTIVE_LOW(0)) u_hi (
        .clk(clk), .rst(rst), .key_in(key_in_hi),
        .key_out(out_hi), .key_press(press_hi), .key_release(rel_hi)
    );

    key_debounce #(.CNT_MAX(CNT), .ACTIVE_LOW(1)) u_lo (
        .clk(clk), .rst(rst), .key_in(key_in_lo),
        .key_out(out_lo), .key_press(press_lo), .key_release(rel_lo)
    );

    // Advance the model by one clock edge given the inputs seen at that edge.
    function automatic exp_t model_step(input logic r, input logic k);
        exp_t e;
        logic ks;
        e = '0;
        if (r) begin
            m_p0  = 1'b0;
            m_p1  = 1'b0;
            m_lvl = 1'b0;
            m_run = 0;
        end else begin
            ks   = m_p1;
            m_p1 = m_p0;
            m_p0 = k;
            if (ks != m_lvl) begin
                m_run = m_run + 1;
                if (m_run == int'(CNT) + 1) begin
                    m_lvl   = ks;
                    m_run   = 0;
                    e.press = ks;
                    e.rel   = ~ks;
                end
            end else begin
                m_run = 0;
            end
        end
        e.lvl = m_lvl;
        return e;
    endfunction

    task automatic cyc_drive(input logic r, input logic k);
        @(negedge clk);
        rst = r;
        kp  = k;
        q.push_back(model_step(r, k));
    endtask

    task automatic hold(input logic k, input int n);
        for (int i = 0; i < n; i++) cyc_drive(1'b0, k);
    endtask

    // Monitor: every rising edge presents one output sample per instance.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty cyc=%0d got nothing queued, required one entry", cyc);
            end else begin
                e = q.pop_front();
                checks++;
                if ({out_hi, press_hi, rel_hi} !== {e.lvl, e.press, e.rel}) begin
                    errors++;
                    $display("FAIL hi_outputs cyc=%0d got out/press/rel=%b%b%b required %b%b%b",
                             cyc, out_hi, press_hi, rel_hi, e.lvl, e.press, e.rel);
                end
                checks++;
                if ({out_lo, press_lo, rel_lo} !== {e.lvl, e.press, e.rel}) begin
                    errors++;
                    $display("FAIL lo_outputs cyc=%0d got out/press/rel=%b%b%b required %b%b%b",
                             cyc, out_lo, press_lo, rel_lo, e.lvl, e.press, e.rel);
                end
            end
        end
    end

    initial begin
        logic k;
        rst   = 1'b1;
        kp    = 1'b0;
        m_p0  = 1'b0;
        m_p1  = 1'b0;
        m_lvl = 1'b0;
        m_run = 0;

        // reset with idle key on both polarities
        cyc_drive(1'b1, 1'b0);
        cyc_drive(1'b1, 1'b0);
        hold(1'b0, 6);

        // clean press, then clean release
        hold(1'b1, 12);
        hold(1'b0, 12);

        // bouncy press: 1,0,1,1,0 then held
        cyc_drive(1'b0, 1'b1);
        cyc_drive(1'b0, 1'b0);
        cyc_drive(1'b0, 1'b1);
        cyc_drive(1'b0, 1'b1);
        cyc_drive(1'b0, 1'b0);
        hold(1'b1, 12);

        // release glitch of two cycles while pressed
        hold(1'b0, 2);
        hold(1'b1, 10);

        // single-cycle glitch exactly at the end of the release window
        hold(1'b0, 5);
        hold(1'b1, 1);
        hold(1'b0, 12);

        // reset mid press filter (cnt=2), key still held afterwards
        hold(1'b1, 5);
        cyc_drive(1'b1, 1'b1);
        hold(1'b1, 12);

        // reset while pressed, key still held: must re-qualify
        cyc_drive(1'b1, 1'b1);
        hold(1'b1, 12);
        hold(1'b0, 12);

        // randomized activity: runs of random length plus rare resets
        for (int i = 0; i < 300; i++) begin
            k = 1'(($urandom_range(0, 1)));
            if ($urandom_range(0, 63) == 0) begin
                cyc_drive(1'b1, k);
            end else begin
                hold(k, int'($urandom_range(1, 9)));
            end
        end
        hold(1'b0, 12);

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
